// File: rtl/colour_reg_writer_pkg.sv
// Shared definitions for the Denise colour-table writer: CLUT geometry, register map and entry layout.
package colour_reg_writer_pkg;

    localparam int CLUT_IDX_W = 5;
    localparam int CLUT_RGB_W = 12;

    localparam logic [8:0] COLOR00_BYTE_ADDR = 9'h180;
    localparam logic [7:0] COLOR00_WORD_ADDR = COLOR00_BYTE_ADDR[8:1];

    typedef struct packed {
        logic [CLUT_IDX_W-1:0] idx;
        logic [CLUT_RGB_W-1:0] rgb;
    } clut_entry_t;

    // The 32 colour registers occupy one aligned block, so only the top three word-address bits select it.
    function automatic logic is_colour_reg(input logic [7:0] addr, input logic [7:0] base);
        return (addr & 8'hE0) == (base & 8'hE0);
    endfunction

endpackage

// File: rtl/colour_reg_writer_sync_fifo.sv
// Small synchronous FIFO holding pending colour writes; pointers carry an extra wrap bit for full/empty.
module colour_reg_writer_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Same low bits with differing wrap bits means the writer has lapped the reader.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/colour_reg_writer.sv
// Writer side of the Denise colour lookup table: decodes COLORxx register writes, queues them and
// issues each one to the CLUT write port only when the timing generator grants a slot.
module colour_reg_writer
    import colour_reg_writer_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter logic [7:0] COLOR_BASE = COLOR00_WORD_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rga_strobe,
    input  logic [7:0]            rga_addr,
    input  logic [15:0]           rga_data,
    input  logic                  wr_slot_en,
    input  logic                  ovf_clr,
    output logic                  cpu_wr,
    output logic [CLUT_IDX_W-1:0] cpu_idx,
    output logic [CLUT_RGB_W-1:0] cpu_rgb,
    output logic                  fifo_full,
    output logic                  busy,
    output logic                  overflow
);

    clut_entry_t           w_entry;
    clut_entry_t           w_head;
    logic                  w_hit;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_unused_data;
    logic                  r_cpu_wr;
    logic [CLUT_IDX_W-1:0] r_cpu_idx;
    logic [CLUT_RGB_W-1:0] r_cpu_rgb;
    logic                  r_overflow;

    assign w_hit         = rga_strobe && is_colour_reg(rga_addr, COLOR_BASE);
    assign w_entry.idx   = rga_addr[CLUT_IDX_W-1:0];
    assign w_entry.rgb   = rga_data[CLUT_RGB_W-1:0];
    assign w_unused_data = ^rga_data[15:12];

    // Pop decisions use registered occupancy only, so a fresh write can never bypass the queue.
    assign w_pop = wr_slot_en && !w_empty;

    colour_reg_writer_sync_fifo #(
        .WIDTH ($bits(clut_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_hit),
        .i_pop   (w_pop),
        .i_wdata (w_entry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_wr  <= 1'b0;
            r_cpu_idx <= '0;
            r_cpu_rgb <= '0;
        end else begin
            r_cpu_wr <= w_pop;
            if (w_pop) begin
                r_cpu_idx <= w_head.idx;
                r_cpu_rgb <= w_head.rgb;
            end
        end
    end

    // A dropped write wins over a clear in the same cycle so no loss goes unreported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_hit && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign cpu_wr    = r_cpu_wr;
    assign cpu_idx   = r_cpu_idx;
    assign cpu_rgb   = r_cpu_rgb;
    assign fifo_full = w_full;
    assign busy      = !w_empty || r_cpu_wr;
    assign overflow  = r_overflow;

endmodule
